// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, UART
// register offsets, FSM states and the load extension helper.
package lsu_pkg;

    // RV32 load size/sign codes
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    // RV32 store size codes
    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    // UART register offsets within the MMIO block
    localparam logic [3:0] MMIO_OFF_TX     = 4'h0;
    localparam logic [3:0] MMIO_OFF_RX     = 4'h4;
    localparam logic [3:0] MMIO_OFF_STATUS = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_e;

    // Select the addressed lane of a memory word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] ext;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_LB:   ext = {{24{sh[7]}}, sh[7:0]};
            F3_LBU:  ext = {24'h00_0000, sh[7:0]};
            F3_LH:   ext = {{16{sh[15]}}, sh[15:0]};
            F3_LHU:  ext = {16'h0000, sh[15:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/lsu_fifo.sv
// Synchronous byte FIFO used for the UART TX and RX queues. A push into a
// full FIFO is accepted when a pop happens in the same cycle.
module lsu_fifo
    import lsu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign dout      = mem_r[rd_ptr_r];

    // Storage array write
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit between the MEM stage and data memory / UART.
// Sub-word accesses with byte enables, a request/ready memory handshake
// that stalls the pipeline, and TX/RX byte FIFOs behind MMIO registers.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses are rejected and
// flagged on misalign_err instead of being forced to natural alignment.
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              TX_DEPTH  = 8,
    parameter int              RX_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(32'h1000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              uart_tx_valid,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_ready,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    state_e      state_r, state_nx_s;
    logic        access_s, is_load_s, is_store_s, is_mmio_s;
    logic        misaligned_s, trap_s, go_mem_s;
    logic [1:0]  off_s;
    logic [3:0]  be_s;
    logic [31:0] lane_data_s;
    logic [3:0]  mmio_off_s;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        rx_overflow_r;
    logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic        rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]  rx_dout_s;
    logic        status_rd_s, rx_drop_s;
    logic [31:0] rdata_s;
    logic        stall_s;

    // Loads take priority when both requests are raised.
    assign access_s   = rd_en | wr_en;
    assign is_load_s  = rd_en;
    assign is_store_s = wr_en & ~rd_en;
    assign is_mmio_s  = (addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
    assign mmio_off_s = {addr[3:2], 2'b00};

    // Size decode: alignment check, lane offset, byte enables, lane data
    always_comb begin
        misaligned_s = 1'b0;
        off_s        = 2'b00;
        be_s         = 4'b1111;
        lane_data_s  = wr_data;
        case (funct3[1:0])
            2'b00: begin
                misaligned_s = 1'b0;
                off_s        = addr[1:0];
                be_s         = 4'b0001 << addr[1:0];
                lane_data_s  = {4{wr_data[7:0]}};
            end
            2'b01: begin
                misaligned_s = addr[0];
                off_s        = {addr[1], 1'b0};
                be_s         = 4'b0011 << {addr[1], 1'b0};
                lane_data_s  = {2{wr_data[15:0]}};
            end
            default: begin
                misaligned_s = (addr[1:0] != 2'b00);
                off_s        = 2'b00;
                be_s         = 4'b1111;
                lane_data_s  = wr_data;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s = access_s & misaligned_s;
`else
    assign trap_s = 1'b0;
`endif

    assign go_mem_s = access_s & ~is_mmio_s & ~trap_s;

    // FSM state register; reset aborts any outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = go_mem_s ? MEM : IDLE;
            MEM:     state_nx_s = mem_ready ? IDLE : MEM;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: stall, load result and FIFO controls
    always_comb begin
        stall_s     = 1'b0;
        rdata_s     = 32'h0000_0000;
        tx_push_s   = 1'b0;
        rx_pop_s    = 1'b0;
        status_rd_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s && is_mmio_s && !trap_s) begin
                    if (is_load_s) begin
                        case (mmio_off_s)
                            MMIO_OFF_RX: begin
                                if (!rx_empty_s) begin
                                    rdata_s  = {24'h00_0000, rx_dout_s};
                                    rx_pop_s = 1'b1;
                                end else begin
                                    rdata_s  = 32'hFFFF_FFFF;
                                end
                            end
                            MMIO_OFF_STATUS: begin
                                rdata_s     = {29'h0, rx_overflow_r, tx_full_s, ~rx_empty_s};
                                status_rd_s = 1'b1;
                            end
                            default: rdata_s = 32'h0000_0000;
                        endcase
                    end else if (mmio_off_s == MMIO_OFF_TX) begin
                        // A slot freed by this cycle's drain can be reused immediately.
                        if (!tx_full_s || tx_pop_s) begin
                            tx_push_s = 1'b1;
                        end else begin
                            stall_s = 1'b1;
                        end
                    end else begin
                        tx_push_s = 1'b0;
                    end
                end else if (go_mem_s) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    rdata_s = load_extend(f3_r, off_r, mem_rdata);
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: stall_s = 1'b0;
        endcase
    end

    // Reset masks the combinational outputs so stall drops at once.
    assign stall   = stall_s & ~rst;
    assign rdata   = rst ? 32'h0000_0000 : rdata_s;
    assign mem_req = (state_r == MEM);

    // Memory request fields, captured when a transaction is launched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= {ADDR_W{1'b0}};
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
            mem_we    <= 1'b0;
            f3_r      <= 3'b000;
            off_r     <= 2'b00;
        end else if (state_r == IDLE && go_mem_s) begin
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be_s;
            mem_wdata <= is_store_s ? lane_data_s : 32'h0000_0000;
            mem_we    <= is_store_s;
            f3_r      <= funct3;
            off_r     <= off_s;
        end
    end

    assign tx_pop_s      = ~tx_empty_s & uart_tx_ready;
    assign uart_tx_valid = ~tx_empty_s;
    assign rx_drop_s     = uart_rx_valid & rx_full_s & ~rx_pop_s;

    // Sticky RX overflow flag; a new drop wins over a clearing read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow_r <= 1'b0;
        end else if (rx_drop_s) begin
            rx_overflow_r <= 1'b1;
        end else if (status_rd_s) begin
            rx_overflow_r <= 1'b0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // One-cycle pulse for each rejected misaligned access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= trap_s & (state_r == IDLE);
        end
    end
`endif

    lsu_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (wr_data[7:0]),
        .dout  (uart_tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    lsu_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid),
        .pop   (rx_pop_s),
        .din   (uart_rx_data),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: directed scenarios plus randomized
// memory traffic against a byte-level reference model.
module tb_lsu_mmio;

    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_RX = 32'h1000_0004;
    localparam logic [31:0] A_ST = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, wr_data = 32'h0;
    logic [31:0] rdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready = 1'b0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] mem_model [64];

    always #5 clk = ~clk;

    lsu_mmio dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .funct3(funct3),
        .addr(addr), .wr_data(wr_data), .rdata(rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .uart_tx_ready(uart_tx_ready), .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int nat_off(input logic [2:0] f3, input logic [31:0] a);
        int s = acc_size(f3);
        return (int'(a[1:0]) / s) * s;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        int s = acc_size(f3);
        int o = nat_off(f3, a);
        for (int i = 0; i < 4; i++) if (i >= o && i < o + s) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int s = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        int s = acc_size(f3);
        logic [31:0] mask = (32'h1 << (8 * s)) - 32'h1;
        logic [31:0] v = (word >> (8 * nat_off(f3, a))) & mask;
        if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic mem_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int delay, input logic [31:0] rword,
                              output logic idle_stall, output logic idle_req, output int req_cycles,
                              output int stall_cycles, output logic ready_stall,
                              output logic [31:0] got_rdata, output logic [31:0] got_addr,
                              output logic [3:0] got_be, output logic [31:0] got_wdata,
                              output logic got_we, output logic held, output logic timeout);
        @(posedge clk); #1;
        rd_en = ld; wr_en = ~ld; funct3 = f3; addr = a; wr_data = wd; mem_ready = 1'b0;
        @(negedge clk);
        idle_stall = stall; idle_req = mem_req;
        req_cycles = 0; stall_cycles = 0; ready_stall = 1'b1; held = 1'b1; timeout = 1'b1;
        got_rdata = 32'h0; got_addr = 32'h0; got_be = 4'h0; got_wdata = 32'h0; got_we = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    got_addr = mem_addr; got_be = mem_be; got_wdata = mem_wdata; got_we = mem_we;
                end else if (got_addr !== mem_addr || got_be !== mem_be ||
                             got_wdata !== mem_wdata || got_we !== mem_we) begin
                    held = 1'b0;
                end
                if (req_cycles >= delay) begin mem_ready = 1'b1; mem_rdata = rword; end
            end
            @(negedge clk);
            if (mem_ready) begin
                ready_stall = stall; got_rdata = rdata; timeout = 1'b0;
                break;
            end else if (stall) begin
                stall_cycles++;
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic mmio_rd(input logic [31:0] a, output logic [31:0] r, output logic st);
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = a;
        @(negedge clk);
        r = rdata; st = stall;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({mem_req, mem_we, stall, uart_tx_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, stall, uart_tx_valid}); end
        checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_fields: got addr=%h be=%h wdata=%h expected 0", mem_addr, mem_be, mem_wdata); end
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_lw_delay();
        logic is_, ir, rs, hd, to, we; int rc, sc; logic [31:0] rd, ad, wd; logic [3:0] be;
        mem_access(1'b1, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL lw_timeout: got timeout expected ready"); end
        checks++; if ({is_, ir} !== 2'b10) begin errors++; $display("FAIL lw_idle: got stall,req=%b expected 10", {is_, ir}); end
        checks++; if (rc != 3 || sc != 2 || rs !== 1'b0) begin
            errors++; $display("FAIL lw_cycles: got req=%0d stall=%0d rstall=%b expected 3 2 0", rc, sc, rs); end
        checks++; if (ad !== 32'h100 || be !== 4'hF || we !== 1'b0 || hd !== 1'b1) begin
            errors++; $display("FAIL lw_fields: got addr=%h be=%h we=%b held=%b expected 100 f 0 1", ad, be, we, hd); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
    endtask

    task automatic test_sb_lb();
        logic is_, ir, rs, hd, to, we; int rc, sc; logic [31:0] rd, ad, wd; logic [3:0] be;
        mem_access(1'b0, 3'b000, 32'h203, 32'h0000_00A5, 1, 32'h0, is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
        checks++; if (ad !== 32'h200 || be !== 4'b1000 || we !== 1'b1 || wd[31:24] !== 8'hA5 || to) begin
            errors++; $display("FAIL sb_fields: got addr=%h be=%b we=%b lane=%h expected 200 1000 1 a5", ad, be, we, wd[31:24]); end
        mem_access(1'b1, 3'b000, 32'h203, 32'h0, 2, 32'h8000_0000, is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
        checks++; if (rd !== 32'hFFFF_FF80 || be !== 4'b1000) begin
            errors++; $display("FAIL lb_sign: got %h be=%b expected ffffff80 1000", rd, be); end
        mem_access(1'b1, 3'b100, 32'h203, 32'h0, 1, 32'h8000_0000, is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zero: got %h expected 00000080", rd); end
    endtask

    task automatic test_random_mem();
        logic is_, ir, rs, hd, to, we; int rc, sc; logic [31:0] rd, ad, wd; logic [3:0] be;
        logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] f3; logic [31:0] a, d, ew; logic ld; int dl, idx; logic [3:0] eb;
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        for (int t = 0; t < 30; t++) begin
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? ld_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
`ifdef LSU_MISALIGN_TRAP_EN
            a  = a & ~32'(acc_size(f3) - 1);
`endif
            d  = $urandom; dl = $urandom_range(1, 4); idx = int'(a[7:2]);
            eb = exp_be(f3, a); ew = exp_wdata(f3, d);
            mem_access(ld, f3, a, d, dl, mem_model[idx], is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
            checks++; if (to || ad !== {a[31:2], 2'b00} || be !== eb || we !== ~ld || rc != dl || hd !== 1'b1) begin
                errors++; $display("FAIL rnd_req[%0d]: got addr=%h be=%b we=%b cyc=%0d expected %h %b %b %0d",
                                   t, ad, be, we, rc, {a[31:2], 2'b00}, eb, ~ld, dl); end
            if (ld) begin
                checks++; if (rd !== exp_load(f3, a, mem_model[idx])) begin
                    errors++; $display("FAIL rnd_load[%0d]: got %h expected %h", t, rd, exp_load(f3, a, mem_model[idx])); end
            end else begin
                checks++; if (wd !== ew) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", t, wd, ew); end
                for (int i = 0; i < 4; i++) if (eb[i]) mem_model[idx][8*i +: 8] = ew[8*i +: 8];
            end
        end
    endtask

    task automatic test_tx_fifo();
        logic [7:0] q [$]; logic [7:0] b; logic [31:0] r; logic st;
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (i == 8) begin
                mmio_rd(A_ST, r, st);
                checks++; if (r !== 32'h2) begin errors++; $display("FAIL tx_status_full: got %h expected 2", r); end
            end
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b1; funct3 = 3'b000; addr = A_TX; wr_data = {24'($urandom), b};
            @(negedge clk);
            if (i < 8) begin
                checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tx_push[%0d]: got stall %b expected 0", i, stall); end
                q.push_back(b);
            end else begin
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tx_full_stall: got %b expected 1", stall); end
                @(posedge clk); #1; @(negedge clk);
                checks++; if (stall !== 1'b1 || uart_tx_valid !== 1'b1 || uart_tx_data !== q[0]) begin
                    errors++; $display("FAIL tx_hold: got stall=%b valid=%b data=%h expected 1 1 %h", stall, uart_tx_valid, uart_tx_data, q[0]); end
                @(posedge clk); #1; uart_tx_ready = 1'b1;
                @(negedge clk);
                checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tx_release: got stall %b expected 0", stall); end
                void'(q.pop_front());
                q.push_back(b);
            end
        end
        @(posedge clk); #1; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== q[0]) begin
                errors++; $display("FAIL tx_drain[%0d]: got valid=%b data=%h expected 1 %h", i, uart_tx_valid, uart_tx_data, q[0]); end
            void'(q.pop_front());
        end
        @(negedge clk);
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty: got %b expected 0", uart_tx_valid); end
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_rx_fifo();
        logic [7:0] q [$]; logic ovf = 1'b0; logic [31:0] r, e; logic st;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            uart_rx_valid = 1'b1; uart_rx_data = 8'($urandom);
            if (q.size() < 8) q.push_back(uart_rx_data); else ovf = 1'b1;
        end
        @(posedge clk); #1; uart_rx_valid = 1'b0;
        mmio_rd(A_ST, r, st);
        e = {29'h0, ovf, 1'b0, q.size() > 0};
        checks++; if (r !== e) begin errors++; $display("FAIL rx_status1: got %h expected %h", r, e); end
        ovf = 1'b0;
        mmio_rd(A_ST, r, st);
        e = {29'h0, ovf, 1'b0, q.size() > 0};
        checks++; if (r !== e) begin errors++; $display("FAIL rx_status2: got %h expected %h", r, e); end
        mmio_rd(A_TX, r, st);
        checks++; if (r !== 32'h0 || st !== 1'b0) begin errors++; $display("FAIL tx_load: got %h stall=%b expected 0 0", r, st); end
        for (int i = 0; i < 9; i++) begin
            e = (q.size() > 0) ? {24'h0, q.pop_front()} : 32'hFFFF_FFFF;
            mmio_rd(A_RX, r, st);
            checks++; if (r !== e || st !== 1'b0) begin
                errors++; $display("FAIL rx_read[%0d]: got %h stall=%b expected %h 0", i, r, st, e); end
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        rd_en = 1'b1; funct3 = 3'b010; addr = 32'h102;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL mis_access: got stall=%b req=%b rdata=%h expected 0 0 0", stall, mem_req, rdata); end
        @(posedge clk); #1; rd_en = 1'b0;
        checks++; if (misalign_err !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL mis_pulse: got err=%b req=%b expected 1 0", misalign_err, mem_req); end
        @(posedge clk); #1;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
`else
        logic is_, ir, rs, hd, to, we; int rc, sc; logic [31:0] rd, ad, wd; logic [3:0] be;
        mem_access(1'b1, 3'b010, 32'h102, 32'h0, 1, 32'h1234_5678, is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
        checks++; if (to || ad !== 32'h100 || be !== 4'hF || rd !== 32'h1234_5678) begin
            errors++; $display("FAIL mis_force: got addr=%h be=%h rdata=%h expected 100 f 12345678", ad, be, rd); end
`endif
    endtask

    task automatic test_reset_mid();
        logic is_, ir, rs, hd, to, we; int rc, sc; logic [31:0] rd, ad, wd; logic [3:0] be;
        logic seen = 1'b0;
        @(posedge clk); #1;
        rd_en = 1'b1; funct3 = 3'b010; addr = 32'h80;
        for (int n = 0; n < 5 && !seen; n++) begin
            @(negedge clk); seen = mem_req;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_req: got req=%b expected 1", seen); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop: got req=%b stall=%b expected 0 0", mem_req, stall); end
        @(posedge clk); #1; rst = 1'b0; rd_en = 1'b0;
        mem_access(1'b1, 3'b010, 32'h40, 32'h0, 2, 32'hCAFE_F00D, is_, ir, rc, sc, rs, rd, ad, be, wd, we, hd, to);
        checks++; if (to || {is_, ir} !== 2'b10 || rc != 2 || ad !== 32'h40 || rd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rstmid_next: got idle=%b cyc=%0d addr=%h rdata=%h expected 10 2 40 cafef00d",
                               {is_, ir}, rc, ad, rd); end
    endtask

    initial begin
        test_reset();
        test_lw_delay();
        test_sb_lb();
        test_random_mem();
        test_tx_fifo();
        test_rx_fifo();
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
